// File: rtl/keypad_scan_fifo.sv
//============================================================================
// Module  : keypad_scan_fifo
// Brief   : Column-scanned keypad matrix with per-key debounce and an event FIFO
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module keypad_scan_fifo #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE       = 3,
  parameter int DEPTH          = 8,
  parameter int REPORT_RELEASE = 0,
  localparam int CW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [COLS-1:0] col,
  input  logic [ROWS-1:0] fila,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [CW-1:0]   ev_code,
  output logic            ev_release,
  output logic            key_down,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int c_col_w   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int c_row_w   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_dwell_w = $clog2(SCAN_DIV);
  localparam int c_db_w    = $clog2(DEBOUNCE + 1);
  localparam int c_addr_w  = $clog2(DEPTH);
  localparam logic [COLS-1:0]   c_col_one = COLS'(1);
  localparam logic [c_addr_w:0] c_depth   = (c_addr_w + 1)'(DEPTH);

  // ---------------- column scan ----------------
  logic                 r_started;
  logic [c_col_w-1:0]   r_col_idx;
  logic [c_col_w-1:0]   w_col_next;
  logic [c_dwell_w-1:0] r_dwell;
  logic [COLS-1:0]      r_col;
  logic                 w_sample;

  assign w_sample   = r_started && (r_dwell == c_dwell_w'(SCAN_DIV - 1));
  assign w_col_next = (r_col_idx == c_col_w'(COLS - 1)) ? '0 : r_col_idx + c_col_w'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_started <= 1'b0;
      r_col_idx <= '0;
      r_dwell   <= '0;
      r_col     <= '1;
    end else if (!r_started) begin
      // First clock out of reset only starts driving column 0; dwell stays at 0.
      r_started <= 1'b1;
      r_col     <= ~c_col_one;
    end else if (w_sample) begin
      r_dwell   <= '0;
      r_col_idx <= w_col_next;
      r_col     <= ~(c_col_one << w_col_next);
    end else begin
      r_dwell <= r_dwell + c_dwell_w'(1);
    end
  end

  assign col = r_col;

  // ---------------- per-key debounce ----------------
  logic              r_stable [ROWS][COLS];
  logic [c_db_w-1:0] r_cnt    [ROWS][COLS];
  logic [ROWS-1:0]   w_cur_stable;
  logic [ROWS-1:0]   w_differs;
  logic [ROWS-1:0]   w_done;
  logic [ROWS-1:0]   w_evt;
  logic              w_any_down;

  always_comb begin
    w_cur_stable = '0;
    w_differs    = '0;
    w_done       = '0;
    w_evt        = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_cur_stable[r] = r_stable[r][r_col_idx];
      w_differs[r]    = (~fila[r]) != w_cur_stable[r];
      w_done[r]       = w_differs[r] && (r_cnt[r][r_col_idx] == c_db_w'(DEBOUNCE - 1));
      w_evt[r]        = w_sample && w_done[r] && (!w_cur_stable[r] || (REPORT_RELEASE != 0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_stable[r][c] <= 1'b0;
          r_cnt[r][c]    <= '0;
        end
      end
    end else if (w_sample) begin
      for (int r = 0; r < ROWS; r++) begin
        if (w_done[r]) begin
          r_stable[r][r_col_idx] <= ~w_cur_stable[r];
          r_cnt[r][r_col_idx]    <= '0;
        end else if (w_differs[r]) begin
          r_cnt[r][r_col_idx] <= r_cnt[r][r_col_idx] + c_db_w'(1);
        end else begin
          r_cnt[r][r_col_idx] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_any_down = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        w_any_down = w_any_down | r_stable[r][c];
      end
    end
  end

  // ---------------- event serialiser ----------------
  logic [ROWS-1:0]    r_pend;
  logic [ROWS-1:0]    r_pend_rel;
  logic [c_col_w-1:0] r_pend_col;
  logic [c_row_w-1:0] w_sel_row;
  logic               w_sel_rel;
  logic               w_push;
  logic [CW-1:0]      w_push_code;

  // Lowest pending row is emitted first, giving ascending row order.
  always_comb begin
    w_sel_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (r_pend[r]) w_sel_row = c_row_w'(r);
    end
  end

  assign w_push      = |r_pend;
  assign w_sel_rel   = r_pend_rel[w_sel_row];
  assign w_push_code = CW'(int'(w_sel_row) * COLS + int'(r_pend_col));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_rel <= '0;
      r_pend_col <= '0;
    end else if (w_sample) begin
      r_pend     <= w_evt;
      r_pend_rel <= w_cur_stable;
      r_pend_col <= r_col_idx;
    end else if (w_push) begin
      r_pend <= r_pend & (r_pend - ROWS'(1));
    end
  end

  // ---------------- first-word-fall-through FIFO ----------------
  logic [CW:0]         r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_count;
  logic                r_ovf;
  logic                r_key_down;
  logic                w_full;
  logic                w_pop;
  logic                w_wr;
  logic                w_drop;

  assign w_full = (r_count == c_depth);
  assign w_pop  = (r_count != '0) && ev_ready;
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_sel_rel, w_push_code};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_key_down <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (c_addr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_addr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
      r_key_down <= w_any_down;
    end
  end

  assign ev_valid   = (r_count != '0);
  assign ev_code    = ev_valid ? r_mem[r_rd_ptr][CW-1:0] : '0;
  assign ev_release = ev_valid ? r_mem[r_rd_ptr][CW] : 1'b0;
  assign key_down   = r_key_down;
  assign overflow   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
//============================================================================
// Module  : tb_keypad_scan_fifo
// Brief   : Scoreboard bench for keypad_scan_fifo (release-reporting and press-only instances)
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_keypad_scan_fifo;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEBOUNCE = 2;
  localparam int DEPTH    = 4;
  localparam int CW       = 4;
  localparam int FRAME    = COLS * SCAN_DIV;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [COLS-1:0] col, col0;
  logic [ROWS-1:0] fila;
  logic            ev_ready = 1'b1;
  logic            ovf_clr  = 1'b0;
  logic            ev_valid, ev_release, key_down, overflow;
  logic [CW-1:0]   ev_code;
  logic            ev_valid0, ev_release0, key_down0, overflow0;
  logic [CW-1:0]   ev_code0;

  bit phys [ROWS][COLS];

  typedef struct {
    logic [CW-1:0] code;
    logic          rel;
    int            due;
    bit            chk_lat;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  bit   m_stable [ROWS][COLS];
  int   m_cnt    [ROWS][COLS];
  bit   exp_ovf1, exp_ovf0;
  int   tests = 0;
  int   fails = 0;
  int   ecnt;

  always #5 clk = ~clk;

  keypad_scan_fifo #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
                     .DEPTH(DEPTH), .REPORT_RELEASE(1)) dut (
    .clk(clk), .rst(rst), .col(col), .fila(fila), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_release(ev_release), .key_down(key_down), .overflow(overflow),
    .ovf_clr(ovf_clr));

  keypad_scan_fifo #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
                     .DEPTH(DEPTH), .REPORT_RELEASE(0)) dut0 (
    .clk(clk), .rst(rst), .col(col0), .fila(fila), .ev_valid(ev_valid0), .ev_ready(ev_ready),
    .ev_code(ev_code0), .ev_release(ev_release0), .key_down(key_down0), .overflow(overflow0),
    .ovf_clr(ovf_clr));

  // Physical matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      fila[r] = 1'b1;
      for (int c = 0; c < COLS; c++) begin
        if (phys[r][c] && !col[c]) fila[r] = 1'b0;
      end
    end
  end

  // Edges since reset release; edge 0 is the one that starts driving column 0.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= -1;
    else     ecnt <= ecnt + 1;
  end

  task automatic model_reset();
    q1.delete();
    q0.delete();
    exp_ovf1 = 1'b0;
    exp_ovf0 = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        m_stable[r][c] = 1'b0;
        m_cnt[r][c]    = 0;
      end
    end
  endtask

  // One sample of column c happens at the coming edge; events land at edges +1, +2, ...
  task automatic model_sample(input int c);
    int j1 = 0;
    int j0 = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (phys[r][c] != m_stable[r][c]) begin
        m_cnt[r][c]++;
        if (m_cnt[r][c] == DEBOUNCE) begin
          exp_t e;
          e.rel          = m_stable[r][c];
          e.code         = CW'(r * COLS + c);
          e.chk_lat      = ev_ready;
          m_stable[r][c] = !m_stable[r][c];
          m_cnt[r][c]    = 0;
          e.due = ecnt + 2 + j1;
          j1++;
          if (!ev_ready && q1.size() >= DEPTH) exp_ovf1 = 1'b1;
          else q1.push_back(e);
          if (!e.rel) begin
            e.due = ecnt + 2 + j0;
            j0++;
            if (!ev_ready && q0.size() >= DEPTH) exp_ovf0 = 1'b1;
            else q0.push_back(e);
          end
        end
      end else begin
        m_cnt[r][c] = 0;
      end
    end
  endtask

  function automatic bit model_any();
    bit a = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        a |= m_stable[r][c];
    return a;
  endfunction

  always @(posedge rst) model_reset();

  always @(negedge clk) begin
    if (!rst && ecnt >= 0 && (ecnt % SCAN_DIV) == SCAN_DIV - 1)
      model_sample((ecnt / SCAN_DIV) % COLS);
  end

  task automatic check_ev(input int which, input logic [CW-1:0] code, input logic rel);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (which == 1) begin
      if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    end else begin
      if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    end
    tests++;
    if (!have) begin
      fails++;
      $display("FAIL unexpected_event rr%0d: got code=%0d rel=%0b at edge %0d, required no event",
               which == 1 ? 1 : 0, code, rel, ecnt);
    end else if (code !== e.code || rel !== e.rel || (e.chk_lat && ecnt != e.due)) begin
      fails++;
      $display("FAIL event rr%0d: got code=%0d rel=%0b edge=%0d, required code=%0d rel=%0b edge=%0d",
               which == 1 ? 1 : 0, code, rel, ecnt, e.code, e.rel, e.chk_lat ? e.due : ecnt);
    end
  endtask

  // Monitor: consumes the scoreboard whenever a DUT hands over an event.
  always @(negedge clk) begin
    if (!rst) begin
      if (ev_valid && ev_ready)  check_ev(1, ev_code, ev_release);
      if (ev_valid0 && ev_ready) check_ev(0, ev_code0, ev_release0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_pos(input int modv, input int pos, input string what);
    int n = 0;
    while (!(ecnt >= 0 && ecnt % modv == pos) && n < 4 * FRAME) begin
      cycles(1);
      n++;
    end
    if (!(ecnt >= 0 && ecnt % modv == pos)) begin
      tests++;
      fails++;
      $display("FAIL timeout_%s: edge=%0d, required position %0d", what, ecnt, pos);
    end
  endtask

  task automatic settle();
    wait_pos(SCAN_DIV, 3, "settle");
  endtask

  task automatic release_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        phys[r][c] = 1'b0;
  endtask

  task automatic chk_drained(input string name);
    chk({name, "_q1"}, q1.size(), 0);
    chk({name, "_q0"}, q0.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    cycles(3);
    chk("rst_col", col, 4'hF);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_code", ev_code, 0);
    chk("rst_ev_release", ev_release, 0);
    chk("rst_key_down", key_down, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ev_valid0", ev_valid0, 0);
    rst = 1'b0;
    cycles(1);
    chk("first_col", col, 4'b1110);

    // Press and hold key 6, then release it.
    phys[1][2] = 1'b1;
    cycles(3 * FRAME); settle();
    chk("hold_key_down", key_down, 1);
    chk("hold_key_down0", key_down0, 1);
    chk_drained("hold");
    phys[1][2] = 1'b0;
    cycles(3 * FRAME); settle();
    chk("release_key_down", key_down, 0);
    chk_drained("release");

    // Single-sample bounce on key 6.
    wait_pos(FRAME, 2 * SCAN_DIV, "bounce_start");
    phys[1][2] = 1'b1;
    cycles(SCAN_DIV);
    phys[1][2] = 1'b0;
    cycles(2 * FRAME); settle();
    chk("bounce_key_down", key_down, 0);
    chk_drained("bounce");

    // Two rows in one column.
    phys[0][1] = 1'b1; phys[3][1] = 1'b1;
    cycles(3 * FRAME); settle();
    chk_drained("two_rows");
    release_all();
    cycles(3 * FRAME); settle();

    // Overflow with consumer stalled.
    ev_ready = 1'b0;
    phys[0][0] = 1'b1; phys[1][0] = 1'b1; phys[1][1] = 1'b1; phys[2][2] = 1'b1; phys[3][3] = 1'b1;
    cycles(3 * FRAME); settle();
    chk("ovf_flag", overflow, exp_ovf1);
    chk("ovf_flag_set", overflow, 1);
    chk("ovf_flag0", overflow0, exp_ovf0);
    chk("ovf_valid", ev_valid, 1);
    chk("ovf_held", q1.size(), DEPTH);
    ev_ready = 1'b1;
    cycles(SCAN_DIV);
    chk("drain_valid", ev_valid, 0);
    chk_drained("drain");
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    exp_ovf1 = 1'b0; exp_ovf0 = 1'b0;
    cycles(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    chk("ovf_cleared0", overflow0, 0);
    release_all();
    cycles(3 * FRAME); settle();

    // Randomised key activity, including bounces of arbitrary length.
    for (int it = 0; it < 40; it++) begin
      int k;
      k = $urandom_range(0, ROWS * COLS - 1);
      phys[k / COLS][k % COLS] = !phys[k / COLS][k % COLS];
      cycles($urandom_range(1, 80));
    end
    cycles(3 * FRAME); settle();
    chk("rand_key_down", key_down, model_any());
    chk("rand_key_down0", key_down0, model_any());
    chk("rand_overflow", overflow, 0);
    chk_drained("rand");
    release_all();
    cycles(3 * FRAME); settle();
    chk_drained("rand_release");

    // Reset mid-frame with key 6 held and one entry queued.
    phys[1][2] = 1'b1;
    cycles(3 * FRAME); settle();
    ev_ready = 1'b0;
    phys[0][0] = 1'b1;
    cycles(3 * FRAME); settle();
    chk("queued_valid", ev_valid, 1);
    wait_pos(FRAME, 10, "mid_frame");
    rst = 1'b1;
    #1;
    chk("mid_rst_col", col, 4'hF);
    chk("mid_rst_ev_valid", ev_valid, 0);
    chk("mid_rst_ev_code", ev_code, 0);
    chk("mid_rst_key_down", key_down, 0);
    chk("mid_rst_overflow", overflow, 0);
    cycles(2);
    rst = 1'b0;
    ev_ready = 1'b1;
    cycles(1);
    chk("post_rst_col", col, 4'b1110);
    cycles(3 * FRAME); settle();
    chk("rereport_key_down", key_down, 1);
    chk_drained("rereport");
    release_all();
    cycles(3 * FRAME); settle();
    chk_drained("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
